// File: rtl/alu_writeback_sequencer.sv
// alu_writeback_sequencer
//   Clocked write-back stage behind the adder and logic units. A start
//   request waits a programmable settle time, then captures the selected
//   result into register A or D, updates the Z/C/S flags and pulses done.
//
// Ports
//   clk, reset_n         rising-edge clock, async active-low reset
//   start                request a write-back (sampled only when idle)
//   dest_sel             0 = reg A, 1 = reg D (captured with start)
//   src_sel              0 = adder, 1 = logic unit (captured with start)
//   adder_out/carry      adder unit sum and carry-out
//   logic_out            logic unit result
//   reg_a, reg_d         destination registers
//   flag_z/c/s           flags from the last write-back
//   alu_bus, bus_en      selected result toward the data bus, 0 when bus_en low
//   busy, done           not-idle indicator, one-cycle completion pulse
module alu_writeback_sequencer #(
    parameter int SETTLE_CYCLES = 3,
    parameter int WIDTH         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             dest_sel,
    input  logic             src_sel,
    input  logic [WIDTH-1:0] adder_out,
    input  logic             adder_carry,
    input  logic [WIDTH-1:0] logic_out,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_d,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_s,
    output logic [WIDTH-1:0] alu_bus,
    output logic             bus_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SETTLE, LOAD, DONE} state_t;

    typedef struct packed {
        logic dest;
        logic src;
    } req_t;

    // A settle time of 0 behaves as 1 cycle.
    localparam int         SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [3:0] CNT_INIT   = 4'(SETTLE_EFF - 1);

    state_t           state;
    req_t             req_q;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] result;

    // Live inputs muxed by the latched source; the capture happens at the
    // LOAD exit edge so late input changes during SETTLE are honoured.
    assign result  = req_q.src ? logic_out : adder_out;
    assign alu_bus = bus_en ? result : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            req_q  <= '0;
            cnt    <= '0;
            reg_a  <= '0;
            reg_d  <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_s <= 1'b0;
            bus_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        req_q  <= '{dest: dest_sel, src: src_sel};
                        cnt    <= CNT_INIT;
                        state  <= SETTLE;
                        bus_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) state <= LOAD;
                    else             cnt   <= cnt - 4'd1;
                end
                LOAD: begin
                    if (req_q.dest) reg_d <= result;
                    else            reg_a <= result;
                    flag_z <= (result == '0);
                    flag_s <= result[WIDTH-1];
                    // Carry only ever comes from the adder.
                    flag_c <= req_q.src ? 1'b0 : adder_carry;
                    state  <= DONE;
                    bus_en <= 1'b0;
                    done   <= 1'b1;
                end
                DONE: begin
                    // start seen here is dropped; it must be re-presented in IDLE.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    bus_en <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback_sequencer.sv
module tb_alu_writeback_sequencer;

    localparam int S = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start, dest_sel, src_sel, adder_carry;
    logic [W-1:0] adder_out, logic_out;
    logic [W-1:0] reg_a, reg_d, alu_bus;
    logic         flag_z, flag_c, flag_s, bus_en, busy, done;

    int tests = 0;
    int fails = 0;

    // Reference state: what the registers/flags must hold after the
    // write-backs issued so far.
    logic [W-1:0] m_a, m_d;
    logic         m_z, m_c, m_s;

    alu_writeback_sequencer #(.SETTLE_CYCLES(S), .WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dest_sel(dest_sel),
        .src_sel(src_sel), .adder_out(adder_out), .adder_carry(adder_carry),
        .logic_out(logic_out), .reg_a(reg_a), .reg_d(reg_d), .flag_z(flag_z),
        .flag_c(flag_c), .flag_s(flag_s), .alu_bus(alu_bus), .bus_en(bus_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".reg_a"}, 32'(reg_a), 32'(m_a));
        check({tag, ".reg_d"}, 32'(reg_d), 32'(m_d));
        check({tag, ".z"}, 32'(flag_z), 32'(m_z));
        check({tag, ".c"}, 32'(flag_c), 32'(m_c));
        check({tag, ".s"}, 32'(flag_s), 32'(m_s));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".bus_en"}, 32'(bus_en), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".alu_bus"}, 32'(alu_bus), 32'd0);
        check_regs(tag);
    endtask

    // Issue one write-back. Called just after a negedge while the DUT is
    // idle; returns just after the negedge of the first idle cycle.
    // Cycle i after the accepting edge: 1..S settle, S+1 load, S+2 done.
    task automatic run_op(input string tag, input bit dest, input bit src,
                          input logic [W-1:0] a, input bit c, input logic [W-1:0] l,
                          input bit hold, input bit late, input logic [W-1:0] a_late,
                          input bit rnd);
        logic [W-1:0] res;
        bit           cy;
        start = 1'b1; dest_sel = dest; src_sel = src;
        adder_out = a; adder_carry = c; logic_out = l;
        @(posedge clk);
        for (int i = 1; i <= S + 3; i++) begin
            @(negedge clk);
            if (i == 1 && !hold) start = 1'b0;
            // Selects are don't-care after acceptance; scramble them.
            dest_sel = 1'($urandom); src_sel = 1'($urandom);
            if (i <= S) begin
                if (late && i == 2) adder_out = a_late;
                if (rnd) begin
                    adder_out = W'($urandom); logic_out = W'($urandom);
                    adder_carry = 1'($urandom);
                end
            end
            if (i == S + 1) begin
                res = src ? logic_out : adder_out;
                cy  = src ? 1'b0 : adder_carry;
            end
            #1;
            if (i == S + 2) begin
                if (dest) m_d = res; else m_a = res;
                m_z = (res == 0); m_c = cy; m_s = res[W-1];
            end
            check({tag, ".busy"}, 32'(busy), 32'(i <= S + 2));
            check({tag, ".bus_en"}, 32'(bus_en), 32'(i <= S + 1));
            check({tag, ".done"}, 32'(done), 32'(i == S + 2));
            check({tag, ".alu_bus"}, 32'(alu_bus),
                  32'((i <= S + 1) ? (src ? logic_out : adder_out) : 8'h00));
            check_regs(tag);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; dest_sel = 1'b0; src_sel = 1'b0;
        adder_out = '0; adder_carry = 1'b0; logic_out = '0;
        m_a = '0; m_d = '0; m_z = 1'b0; m_c = 1'b0; m_s = 1'b0;
        #1;
        check_quiet("reset");
        #20;
        @(negedge clk); reset_n = 1'b1; #1;

        // Prior write so reg_a holds 0x42, then abort a write mid-settle.
        run_op("pre42", 0, 0, 8'h42, 0, 8'h00, 0, 0, 8'h00, 0);
        start = 1'b1; dest_sel = 1'b0; src_sel = 1'b0; adder_out = 8'h10;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk); #2;
        check("midsettle.bus_en", 32'(bus_en), 32'd1);
        reset_n = 1'b0; #1;
        m_a = '0; m_d = '0; m_z = 1'b0; m_c = 1'b0; m_s = 1'b0;
        check_quiet("async_rst");
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check_quiet("post_rst");
        end

        // ADD to A, then wrap to zero into D, then logic source clears carry.
        run_op("add_a", 0, 0, 8'h02, 0, 8'h77, 0, 0, 8'h00, 0);
        run_op("wrap_d", 1, 0, 8'h00, 1, 8'h33, 0, 0, 8'h00, 0);
        run_op("logic_a", 0, 1, 8'h00, 1, 8'h80, 0, 0, 8'h00, 0);

        // Late adder change with start held: the second request must be
        // taken at the first idle edge (k+S+3), not during DONE.
        run_op("late", 0, 0, 8'h11, 0, 8'h5A, 1, 1, 8'h22, 0);
        run_op("b2b", 1, 1, 8'h00, 1, 8'hC3, 0, 0, 8'h00, 0);

        // Randomized write-backs with inputs wandering during settle.
        for (int n = 0; n < 20; n++) begin
            run_op("rand", 1'($urandom), 1'($urandom), W'($urandom), 1'($urandom),
                   W'($urandom), 1'($urandom), 0, 8'h00, 1'($urandom));
        end
        start = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        check_quiet("final_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_writeback_sequencer.md
Name: alu_writeback_sequencer

Overview:
- Sits directly downstream of the 8-bit adder unit and the logic unit; consumes the adder sum/carry or the logic result.
- Sequences one ALU write-back:
  - waits a programmable settle time that emulates relay propagation delay;
  - latches the selected result into destination register A or D;
  - updates the Z/C/S condition flags;
  - pulses done.
- Replaces ad-hoc #delay sampling with a clocked, handshaked stage the instruction sequencer can drive.

Parameters:
- SETTLE_CYCLES, 3, clock cycles the ALU inputs must be stable before capture; legal range 1..15, value 0 treated as 1.
- WIDTH, 8, datapath width; flag S taken from bit WIDTH-1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a write-back; sampled only in IDLE.
- dest_sel  input  1  0 = register A, 1 = register D; captured with start.
- src_sel  input  1  0 = adder result, 1 = logic-unit result; captured with start.
- adder_out  input  WIDTH  sum from adder unit.
- adder_carry  input  1  carry-out from adder unit.
- logic_out  input  WIDTH  result from logic unit.
- reg_a  output  WIDTH  register A contents.
- reg_d  output  WIDTH  register D contents.
- flag_z  output  1  result == 0 on last write-back.
- flag_c  output  1  carry on last write-back.
- flag_s  output  1  result MSB on last write-back.
- alu_bus  output  WIDTH  selected result driven toward data bus; 0 when bus_en low.
- bus_en  output  1  high in SETTLE and LOAD.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after capture.

Behaviour:
- Reset (reset_n low, async, any state):
  - state = IDLE; settle counter = 0;
  - reg_a = reg_d = 0; flag_z/c/s = 0;
  - alu_bus = 0; bus_en = busy = done = 0.
- Reset mid-operation aborts with no register or flag update. First start is accepted on the first edge after reset_n rises.
- States: IDLE, SETTLE, LOAD, DONE.
- IDLE:
  - start=1 at edge → latch dest_sel and src_sel, counter = SETTLE_CYCLES-1, go to SETTLE.
  - start=0 → remain in IDLE.
- SETTLE:
  - bus_en=1; alu_bus = mux(src_sel latched) of live inputs.
  - counter==0 → go to LOAD; else decrement.
- LOAD (exactly one cycle):
  - At the exiting edge, capture the selected result into reg_a or reg_d (latched dest_sel).
  - flag_z = (result==0); flag_s = result[WIDTH-1].
  - flag_c = adder_carry if src adder, else 0.
  - Next state is DONE.
- DONE:
  - done=1, busy=1, bus_en=0.
  - Next state is IDLE unconditionally.
  - start asserted in DONE is ignored and must be reasserted in IDLE.
- Latency:
  - start edge k → LOAD capture at edge k+SETTLE_CYCLES+1;
  - done high during the cycle after that edge;
  - next start accepted at edge k+SETTLE_CYCLES+3.
- start while busy: ignored; latched selects are unchanged.
- The non-selected destination register always holds its value. Flags change only at LOAD.
- Input changes during SETTLE are legal; only values present at the LOAD edge are captured.
- Adder overflow wraps mod 2^WIDTH; no saturation. Carry comes solely from adder_carry.

Test Plan:
- Reset mid-SETTLE:
  - Setup: reg_a=0x42 from a prior write; start, dest=A, src adder, adder_out=0x10.
  - Action: drop reset_n during SETTLE.
  - Required: all outputs go to 0 immediately (async); no done pulse; state returns to IDLE.
- ADD to A, SETTLE_CYCLES=3:
  - Stimulus: start, dest=A, src adder, adder_out=0x02, carry=0.
  - Required: busy high 5 cycles; reg_a=0x02 at edge k+4; done one cycle; Z=0 C=0 S=0; reg_d unchanged (0).
- Wrap to zero:
  - Stimulus: adder_out=0x00, carry=1 (0xFF+0x01), dest=D.
  - Required: reg_d=0x00, Z=1, C=1, S=0; reg_a holds prior value.
- Logic source clears carry:
  - Setup: previous C=1.
  - Stimulus: src logic, logic_out=0x80, dest=A.
  - Required: reg_a=0x80, Z=0, C=0, S=1; alu_bus=0x80 while bus_en high, 0 otherwise.
- Late input change, back-to-back start:
  - Stimulus: change adder_out 0x11→0x22 mid-SETTLE; hold start high continuously.
  - Required: captured value 0x22; exactly one done per accepted request; second request accepted only on return to IDLE (edge k+6 for SETTLE_CYCLES=3).
